shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised, multi-cycle shift/rotate unit for the CPU datapath, with a handshake interface. It generalises the 16-bit combinational shifter to WIDTH bits and five modes (logical/arithmetic shifts and rotates), and adds a carry-out and an illegal-opcode flag. It shifts iteratively by up to STEP bits per cycle, so wide-datapath configurations can trade latency for area. It sits beside the ALU and is started by the control unit.

## Interface
- WIDTH, 16, data width; power of two, ≥4
- STEP, 1, maximum bits shifted per cycle; power of two, 1..WIDTH
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request; accepted only in a cycle where Ready=1
- Hyrja  in  WIDTH  operand; sampled on accept
- Shamt  in  SHAMT_W  shift amount 0..WIDTH-1; sampled on accept
- Funct  in  3  mode: 000 SLL, 001 SRA, 010 SRL, 011 ROL, 100 ROR; 101–111 illegal
- Ready  out  1  unit idle (state==IDLE decode)
- Done  out  1  one-cycle pulse; Result, Carry and Error are valid
- Result  out  WIDTH  shifted value; held until the next Done
- Carry  out  1  last bit shifted out; held with Result
- Error  out  1  illegal Funct; held with Result

## Operation
- Registers: Acc (WIDTH), Cnt (SHAMT_W), Op (3), Result, Carry, Error, state.
- States:
  - IDLE
    - Start=1: Acc←Hyrja, Cnt←Shamt, Op←Funct, Carry←0, then go to SHIFT.
    - Illegal Funct: Cnt←0 and Error←1; otherwise Error←0.
  - SHIFT
    - Cnt≠0: let n=min(Cnt,STEP). Shift Acc by n per Op, set Cnt←Cnt−n, and update Carry. Stay in SHIFT.
    - Cnt=0: Result←Acc, then go to DONE.
  - DONE: Done=1 for one cycle, then go to IDLE.
- Per-step arithmetic:
  - SLL: zero-fill from the LSB.
  - SRA: replicate the MSB.
  - SRL: zero-fill from the MSB.
  - ROL/ROR: circular.
- Carry:
  - SLL: final Carry equals original bit WIDTH−Shamt.
  - SRA/SRL: final Carry equals original bit Shamt−1.
  - Rotates, Shamt=0 and illegal Funct: Carry=0.
- Illegal Funct: Result=Hyrja unchanged, Error=1, normal Done timing for Shamt=0.
- Start while Ready=0 is ignored, with no queueing. Inputs are don't-care except in the accept cycle.
- Shamt only spans 0..WIDTH-1, so shifts of WIDTH or more cannot occur.

## Timing
- Let k=ceil(Shamt/STEP), with k=0 for illegal Funct.
- Accept at edge 0. Done is high in the cycle following edge k+1, i.e. latency k+1 cycles. Result/Carry/Error update on the same edge.
- Ready returns 1 after edge k+2. Back-to-back issue: one op per k+3 cycles.
- Reset values: state=IDLE (Ready=1), Done=0, Result=0, Carry=0, Error=0, Acc=0, Cnt=0.
- Reset asserted mid-SHIFT or in DONE: outputs take reset values immediately and asynchronously. The in-flight op is discarded and no Done is produced.
- Start held high continuously: a new op is accepted in the first Ready=1 cycle after each DONE.

## Structure
- Package shift_pkg holds:
  - the Funct localparams FN_SLL, FN_SRA, FN_SRL, FN_ROL, FN_ROR;
  - the state encoding S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step (combinational):
  - inputs: value, amount 0..STEP, Op;
  - outputs: shifted value and last bit out.
- The top level instantiates one shift_step, the FSM and the registers.

## Test plan
- WIDTH=16, STEP=1, SLL, Hyrja=0x0001, Shamt=2 → Result=0x0004, Carry=0, Done 3 cycles after accept.
- STEP=1, SRA, Hyrja=0x8400, Shamt=6 → Result=0xFE10, Carry=0. Then SRL, Hyrja=0x8001, Shamt=1 → Result=0x4000, Carry=1.
- STEP=4, ROL, Hyrja=0x1234, Shamt=15 → Result=0x091A, Done 5 cycles after accept. ROR, 0x0001, Shamt=1 → 0x8000.
- Funct=3'b111, Hyrja=0xBEEF, Shamt=9 → Result=0xBEEF, Error=1, Done 1 cycle after accept. The next legal op clears Error.
- Start pulsed during SHIFT with different operands → ignored; Result matches the first op only. Exactly one Done pulse.
- Reset asserted mid-SHIFT → Ready=1 and Result=0 asynchronously, no Done. A new op after release completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_pkg
// Brief   : Funct codes, FSM state encoding and opcode helper for shift_unit_seq
// Revision: 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam logic [2:0] FN_SLL = 3'b000;
  localparam logic [2:0] FN_SRA = 3'b001;
  localparam logic [2:0] FN_SRL = 3'b010;
  localparam logic [2:0] FN_ROL = 3'b011;
  localparam logic [2:0] FN_ROR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic fn_legal(input logic [2:0] f);
    return (f <= FN_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module  : shift_step
// Brief   : Combinational single-step shifter/rotator, 0..STEP bits per call
// Revision: 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 1
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [AMT_W-1:0] i_amount,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_value,
  output logic             o_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]           w_a;
  logic [CW-1:0]           w_inv;
  logic [WIDTH:0]          w_sl;
  logic [WIDTH:0]          w_sr;
  logic signed [WIDTH:0]   w_sa;
  logic [WIDTH-1:0]        w_rol;
  logic [WIDTH-1:0]        w_ror;

  assign w_a   = CW'(i_amount);
  assign w_inv = CW'(WIDTH) - w_a;

  // One guard bit beyond the data catches the last bit shifted out.
  assign w_sl  = {1'b0, i_value} << w_a;
  assign w_sr  = {i_value, 1'b0} >> w_a;
  assign w_sa  = $signed({i_value, 1'b0}) >>> w_a;
  assign w_rol = (i_value << w_a) | (i_value >> w_inv);
  assign w_ror = (i_value >> w_a) | (i_value << w_inv);

  always_comb begin
    o_value = i_value;
    o_out   = 1'b0;
    case (i_op)
      FN_SLL: begin o_value = w_sl[WIDTH-1:0]; o_out = w_sl[WIDTH]; end
      FN_SRA: begin o_value = w_sa[WIDTH:1];   o_out = w_sa[0];     end
      FN_SRL: begin o_value = w_sr[WIDTH:1];   o_out = w_sr[0];     end
      FN_ROL: o_value = w_rol;
      FN_ROR: o_value = w_ror;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module  : shift_unit_seq
// Brief   : Multi-cycle shift/rotate unit, up to STEP bits per cycle, handshake
// Revision: 1.0 - initial release
// ============================================================================
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_hyrja,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [2:0]         i_funct,
  output logic               o_ready,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_carry,
  output logic               o_error
);

  localparam int             AMT_W  = $clog2(STEP) + 1;
  localparam logic [SHAMT_W:0] C_STEP = (SHAMT_W+1)'(STEP);

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_op;
  logic               r_cy;
  logic               r_ill;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_error;

  logic [SHAMT_W:0]   w_n;
  logic [WIDTH-1:0]   w_step_val;
  logic               w_step_out;

  assign w_n = ({1'b0, r_cnt} > C_STEP) ? C_STEP : {1'b0, r_cnt};

  shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .i_value  (r_acc),
    .i_amount (AMT_W'(w_n)),
    .i_op     (r_op),
    .o_value  (w_step_val),
    .o_out    (w_step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= FN_SLL;
      r_cy     <= 1'b0;
      r_ill    <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc   <= i_hyrja;
            r_op    <= i_funct;
            r_cy    <= 1'b0;
            r_state <= S_SHIFT;
            // An illegal opcode passes the operand through untouched.
            if (fn_legal(i_funct)) begin
              r_cnt <= i_shamt;
              r_ill <= 1'b0;
            end else begin
              r_cnt <= '0;
              r_ill <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_step_val;
            r_cnt <= SHAMT_W'({1'b0, r_cnt} - w_n);
            r_cy  <= w_step_out;
          end else begin
            r_result <= r_acc;
            r_carry  <= r_cy;
            r_error  <= r_ill;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_unit_seq
// Brief   : Self-checking bench, STEP=1 and STEP=4 instances against a model
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hyrja = '0;
  logic [3:0]  shamt = '0;
  logic [2:0]  funct = '0;

  logic        rdy1, dn1, cy1, er1;
  logic [15:0] res1;
  logic        rdy4, dn4, cy4, er4;
  logic [15:0] res4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start), .i_hyrja(hyrja), .i_shamt(shamt),
    .i_funct(funct), .o_ready(rdy1), .o_done(dn1), .o_result(res1),
    .o_carry(cy1), .o_error(er1)
  );

  shift_unit_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start), .i_hyrja(hyrja), .i_shamt(shamt),
    .i_funct(funct), .o_ready(rdy4), .o_done(dn4), .o_result(res4),
    .o_carry(cy4), .o_error(er4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the mode definitions, on whole-operand arithmetic.
  function automatic void model(input logic [2:0] f, input logic [15:0] a, input int n,
                                output logic [15:0] r, output logic c, output logic e);
    r = a; c = 1'b0; e = 1'b0;
    case (f)
      3'd0: begin r = a << n; c = (n != 0) && (((a >> (16 - n)) & 16'd1) != 0); end
      3'd1: begin r = 16'($signed(a) >>> n); c = (n != 0) && (((a >> (n - 1)) & 16'd1) != 0); end
      3'd2: begin r = a >> n; c = (n != 0) && (((a >> (n - 1)) & 16'd1) != 0); end
      3'd3: r = (a << n) | (a >> (16 - n));
      3'd4: r = (a >> n) | (a << (16 - n));
      default: e = 1'b1;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input int n, input int step);
    if (f > 3'd4) return 1;
    return (n + step - 1) / step + 1;
  endfunction

  task automatic run_op(input string nm, input logic [2:0] f, input logic [15:0] a,
                        input int n, input bit poke);
    logic [15:0] er; logic ec, ee;
    logic [15:0] r1, r4; logic c1, c4, e1, e4;
    int lat1, lat4, nd1, nd4;
    model(f, a, n, er, ec, ee);
    lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0;
    r1 = 'x; r4 = 'x; c1 = 'x; c4 = 'x; e1 = 'x; e4 = 'x;
    @(negedge clk);
    chk({nm, " ready1 before"}, 32'(rdy1), 32'd1);
    chk({nm, " ready4 before"}, 32'(rdy4), 32'd1);
    funct = f; hyrja = a; shamt = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hyrja = 16'($urandom); shamt = 4'($urandom); funct = 3'($urandom);
    for (int c = 1; c <= 30; c++) begin
      if (poke && c == 2) begin
        start = 1'b1; hyrja = ~a; shamt = 4'(n) ^ 4'd1; funct = 3'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (dn1) begin nd1++; if (lat1 < 0) begin lat1 = c; r1 = res1; c1 = cy1; e1 = er1; end end
      if (dn4) begin nd4++; if (lat4 < 0) begin lat4 = c; r4 = res4; c4 = cy4; e4 = er4; end end
    end
    chk({nm, " s1 result"}, 32'(r1), 32'(er));
    chk({nm, " s1 carry"},  32'(c1), 32'(ec));
    chk({nm, " s1 error"},  32'(e1), 32'(ee));
    chk({nm, " s1 latency"}, 32'(lat1), 32'(latency(f, n, 1)));
    chk({nm, " s1 done pulses"}, 32'(nd1), 32'd1);
    chk({nm, " s1 result held"}, 32'(res1), 32'(er));
    chk({nm, " s4 result"}, 32'(r4), 32'(er));
    chk({nm, " s4 carry"},  32'(c4), 32'(ec));
    chk({nm, " s4 error"},  32'(e4), 32'(ee));
    chk({nm, " s4 latency"}, 32'(lat4), 32'(latency(f, n, 4)));
    chk({nm, " s4 done pulses"}, 32'(nd4), 32'd1);
  endtask

  initial begin
    int nd1, nd4;
    #1;
    chk("reset ready1",  32'(rdy1), 32'd1);
    chk("reset ready4",  32'(rdy4), 32'd1);
    chk("reset done1",   32'(dn1),  32'd0);
    chk("reset result1", 32'(res1), 32'd0);
    chk("reset carry4",  32'(cy4),  32'd0);
    chk("reset error4",  32'(er4),  32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("sll1",    3'd0, 16'h0001,  2, 1'b0);
    run_op("sra",     3'd1, 16'h8400,  6, 1'b0);
    run_op("srl",     3'd2, 16'h8001,  1, 1'b0);
    run_op("rol",     3'd3, 16'h1234, 15, 1'b0);
    run_op("ror",     3'd4, 16'h0001,  1, 1'b0);
    run_op("illegal", 3'd7, 16'hBEEF,  9, 1'b0);
    run_op("clrerr",  3'd0, 16'h00FF,  4, 1'b0);
    run_op("sll15",   3'd0, 16'h8001, 15, 1'b0);
    run_op("sra0",    3'd1, 16'h8421,  0, 1'b0);
    run_op("poke",    3'd2, 16'hF0F1, 15, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 15)), 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    funct = 3'd0; hyrja = 16'h1234; shamt = 4'd15; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst ready1",  32'(rdy1), 32'd1);
    chk("midrst ready4",  32'(rdy4), 32'd1);
    chk("midrst result1", 32'(res1), 32'd0);
    chk("midrst result4", 32'(res4), 32'd0);
    chk("midrst done1",   32'(dn1),  32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    nd1 = 0; nd4 = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (dn1) nd1++;
      if (dn4) nd4++;
    end
    chk("midrst no done1", 32'(nd1), 32'd0);
    chk("midrst no done4", 32'(nd4), 32'd0);
    run_op("after rst", 3'd1, 16'h9000, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
